// File: rtl/io_pad_mux.sv
// io_pad_mux: run-time configurable pad multiplexer with input conditioning.
// Each pad picks one peripheral out/oeb pair via a Wishbone-programmed config
// register. Pad inputs are synchronised, optionally glitch-filtered and
// inverted, then broadcast back to every peripheral.
module io_pad_mux #(
   parameter int unsigned N_PADS = 38,
   parameter int unsigned N_FUNC = 4,
   parameter int unsigned FILT_W = 4
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       wbs_stb_i,
   input  logic                       wbs_cyc_i,
   input  logic                       wbs_we_i,
   input  logic [3:0]                 wbs_sel_i,
   input  logic [31:0]                wbs_adr_i,
   input  logic [31:0]                wbs_dat_i,
   output logic                       wbs_ack_o,
   output logic [31:0]                wbs_dat_o,
   input  logic [N_PADS*N_FUNC-1:0]   fn_out_i,
   input  logic [N_PADS*N_FUNC-1:0]   fn_oeb_i,
   output logic [N_PADS-1:0]          fn_in_o,
   input  logic [N_PADS-1:0]          io_in,
   output logic [N_PADS-1:0]          io_out,
   output logic [N_PADS-1:0]          io_oeb
);

   localparam int unsigned FSEL_W   = (N_FUNC > 1) ? $clog2(N_FUNC) : 1;
   localparam int unsigned FILT_MAX = (2 ** FILT_W) - 1;
   localparam int unsigned W_IN_LO  = 64;
   localparam int unsigned W_IN_HI  = 65;

   // Per-pad configuration
   logic [FSEL_W-1:0] r_fsel [N_PADS];
   logic [N_PADS-1:0] r_filt_en;
   logic [N_PADS-1:0] r_force_in;
   logic [N_PADS-1:0] r_inv;

   // Input conditioning state
   logic [N_PADS-1:0] r_s1;
   logic [N_PADS-1:0] r_s2;
   logic [N_PADS-1:0] r_filt;
   logic [FILT_W-1:0] r_cnt [N_PADS];

   // Bus interface state
   logic        r_ack;
   logic [31:0] r_dat;

   logic        w_access;
   logic        w_wr;
   logic [7:0]  w_word;
   logic [31:0] w_rd_data;
   logic [N_PADS-1:0] w_fn_in;
   logic [63:0] w_fn_in_64;
   logic [N_PADS-1:0] w_io_out;
   logic [N_PADS-1:0] w_io_oeb;
   logic        w_unused;

   assign w_access   = wbs_stb_i & wbs_cyc_i & ~r_ack;
   assign w_wr       = w_access & wbs_we_i;
   assign w_word     = wbs_adr_i[9:2];
   assign w_fn_in    = r_filt ^ r_inv;
   assign w_fn_in_64 = 64'(w_fn_in);

   // Address bits outside the word index, upper data bits and sel[3:2] carry no meaning here
   assign w_unused = ^{wbs_adr_i[31:10], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i[3:2]};

   // Config register writes; sel[0] gates the fsel byte, sel[1] the flag byte
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int p = 0; p < int'(N_PADS); p++) begin
            r_fsel[p] <= '0;
         end
         r_filt_en  <= '0;
         r_force_in <= '1;
         r_inv      <= '0;
      end else begin
         for (int p = 0; p < int'(N_PADS); p++) begin
            if (w_wr && (w_word == 8'(p))) begin
               if (wbs_sel_i[0]) begin
                  r_fsel[p] <= wbs_dat_i[FSEL_W-1:0];
               end
               if (wbs_sel_i[1]) begin
                  r_filt_en[p]  <= wbs_dat_i[8];
                  r_force_in[p] <= wbs_dat_i[9];
                  r_inv[p]      <= wbs_dat_i[10];
               end
            end
         end
      end
   end

   // Read-data mux: config words, then the two conditioned-input status words
   always_comb begin
      w_rd_data = '0;
      for (int p = 0; p < int'(N_PADS); p++) begin
         if (w_word == 8'(p)) begin
            w_rd_data = {21'b0, r_inv[p], r_force_in[p], r_filt_en[p], 8'(r_fsel[p])};
         end
      end
      if (w_word == 8'(W_IN_LO)) begin
         w_rd_data = w_fn_in_64[31:0];
      end
      if (w_word == 8'(W_IN_HI)) begin
         w_rd_data = w_fn_in_64[63:32];
      end
   end

   // Single-cycle ack with a forced idle cycle; read data is zero outside ack
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_access;
         r_dat <= (w_access && !wbs_we_i) ? w_rd_data : '0;
      end
   end

   // Synchroniser and per-pad glitch filter
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_filt <= '0;
         for (int p = 0; p < int'(N_PADS); p++) begin
            r_cnt[p] <= '0;
         end
      end else begin
         r_s1 <= io_in;
         r_s2 <= r_s1;
         for (int p = 0; p < int'(N_PADS); p++) begin
            if (!r_filt_en[p]) begin
               r_filt[p] <= r_s2[p];
               r_cnt[p]  <= '0;
            end else if (r_s2[p] == r_filt[p]) begin
               r_cnt[p] <= '0;
            end else if (r_cnt[p] == FILT_W'(FILT_MAX - 1)) begin
               r_filt[p] <= r_s2[p];
               r_cnt[p]  <= '0;
            end else begin
               r_cnt[p] <= r_cnt[p] + FILT_W'(1);
            end
         end
      end
   end

   // Output mux; an out-of-range fsel parks the pad as an input driving 0
   always_comb begin
      w_io_out = '0;
      w_io_oeb = '1;
      for (int p = 0; p < int'(N_PADS); p++) begin
         for (int f = 0; f < int'(N_FUNC); f++) begin
            if (r_fsel[p] == FSEL_W'(f)) begin
               w_io_out[p] = fn_out_i[p*int'(N_FUNC) + f];
               w_io_oeb[p] = r_force_in[p] | fn_oeb_i[p*int'(N_FUNC) + f];
            end
         end
      end
   end

   assign io_out    = w_io_out;
   assign io_oeb    = w_io_oeb;
   assign fn_in_o   = w_fn_in;
   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_io_pad_mux.sv
// Self-checking bench for io_pad_mux: table-driven mux vectors, a read
// scoreboard, and hand sequences for filter timing, handshake and reset.
module tb_io_pad_mux;

   localparam int unsigned N_PADS = 38;
   localparam int unsigned N_FUNC = 4;
   localparam int unsigned FILT_W = 4;

   logic                      clk;
   logic                      rst;
   logic                      stb;
   logic                      cyc;
   logic                      we;
   logic [3:0]                sel;
   logic [31:0]               adr;
   logic [31:0]               dat_w;
   logic                      ack;
   logic [31:0]               dat_r;
   logic [N_PADS*N_FUNC-1:0]  fn_out;
   logic [N_PADS*N_FUNC-1:0]  fn_oeb;
   logic [N_PADS-1:0]         fn_in;
   logic [N_PADS-1:0]         io_in;
   logic [N_PADS-1:0]         io_out;
   logic [N_PADS-1:0]         io_oeb;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      int          pad;
      logic [31:0] wdat;
      logic [3:0]  wsel;
      logic [3:0]  fout;
      logic [3:0]  foeb;
      logic [31:0] exp_cfg;
      logic        exp_out;
      logic        exp_oeb;
   } vec_t;

   vec_t vecs[9];

   io_pad_mux #(.N_PADS(N_PADS), .N_FUNC(N_FUNC), .FILT_W(FILT_W)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_w),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_r),
      .fn_out_i  (fn_out),
      .fn_oeb_i  (fn_oeb),
      .fn_in_o   (fn_in),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oeb    (io_oeb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic wb_wr(input logic [7:0] w, input logic [31:0] d, input logic [3:0] s);
      logic got;
      adr = {22'b0, w, 2'b00};
      dat_w = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (ack) got = 1'b1;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      chk("wr_ack", 64'(got), 64'd1);
      step();
   endtask

   task automatic wb_rd(input logic [7:0] w, input logic [31:0] exp, input string nm);
      logic got;
      logic [31:0] e;
      sb_q.push_back(exp);
      adr = {22'b0, w, 2'b00};
      sel = 4'hf; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (ack) got = 1'b1;
      end
      e = sb_q.pop_front();
      if (got) chk(nm, 64'(dat_r), 64'(e));
      else chk({nm, "_ack_timeout"}, 64'(got), 64'd1);
      stb = 1'b0; cyc = 1'b0;
      step();
   endtask

   initial begin
      bit seen;
      vecs[0] = '{5,  32'h0000_0002, 4'b0011, 4'b0100, 4'b0000, 32'h002, 1'b1, 1'b0};
      vecs[1] = '{0,  32'h0000_0003, 4'b0011, 4'b0111, 4'b1000, 32'h003, 1'b0, 1'b1};
      vecs[2] = '{37, 32'h0000_0201, 4'b0011, 4'b0010, 4'b0000, 32'h201, 1'b1, 1'b1};
      vecs[3] = '{12, 32'h0000_0700, 4'b0011, 4'b0001, 4'b0000, 32'h700, 1'b1, 1'b1};
      vecs[4] = '{20, 32'hFFFF_F8F1, 4'b1111, 4'b0010, 4'b1101, 32'h001, 1'b1, 1'b0};
      vecs[5] = '{7,  32'h0000_00FC, 4'b0011, 4'b1110, 4'b0001, 32'h000, 1'b0, 1'b1};
      vecs[6] = '{6,  32'h0000_0002, 4'b0001, 4'b0100, 4'b0000, 32'h202, 1'b1, 1'b1};
      vecs[7] = '{5,  32'h0000_0600, 4'b0001, 4'b0001, 4'b0000, 32'h000, 1'b1, 1'b0};
      vecs[8] = '{9,  32'h0000_0300, 4'b0010, 4'b0001, 4'b0000, 32'h300, 1'b1, 1'b1};

      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      adr = '0; dat_w = '0; fn_out = '0; fn_oeb = '0; io_in = '0;
      step(); step();
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_dat", 64'(dat_r), 64'd0);
      rst = 1'b0;
      step();

      // T1: reset state
      chk("t1_oeb_all", 64'(io_oeb), 64'h3F_FFFF_FFFF);
      chk("t1_fn_in", 64'(fn_in), 64'd0);
      wb_rd(8'd0, 32'h200, "t1_cfg0");
      wb_rd(8'd70, 32'h0, "t1_w70");
      wb_rd(8'd64, 32'h0, "t1_in_lo");
      // write with cyc low must be ignored
      adr = 32'd4; dat_w = 32'h0; sel = 4'hf; we = 1'b1; stb = 1'b1; cyc = 1'b0;
      step();
      chk("t1_nocyc_ack", 64'(ack), 64'd0);
      stb = 1'b0; we = 1'b0;
      step();
      wb_rd(8'd1, 32'h200, "t1_nocyc_cfg1");

      io_in[33] = 1'b1;
      io_in[37] = 1'b1;

      // T3: unfiltered latency and inversion
      io_in[3] = 1'b1;
      step(); step();
      chk("t3_edge2", 64'(fn_in[3]), 64'd0);
      step();
      chk("t3_edge3", 64'(fn_in[3]), 64'd1);
      wb_rd(8'd64, 32'h8, "t3_in_lo");
      wb_wr(8'd3, 32'h600, 4'b0010);
      chk("t3_inv", 64'(fn_in[3]), 64'd0);
      wb_rd(8'd64, 32'h0, "t3_in_lo_inv");

      // T4: glitch filter on pad 10
      wb_wr(8'd10, 32'h100, 4'b0010);
      seen = 1'b0;
      io_in[10] = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step();
         if (fn_in[10]) seen = 1'b1;
      end
      io_in[10] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (fn_in[10]) seen = 1'b1;
      end
      chk("t4_reject14", 64'(seen), 64'd0);
      io_in[10] = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         if (i == 15) io_in[10] = 1'b0;
         if (i == 16) chk("t4_rise_e16", 64'(fn_in[10]), 64'd0);
         if (i == 17) chk("t4_rise_e17", 64'(fn_in[10]), 64'd1);
      end
      for (int i = 1; i <= 15; i++) begin
         step();
         if (i == 14) chk("t4_fall_hold", 64'(fn_in[10]), 64'd1);
         if (i == 15) chk("t4_fall", 64'(fn_in[10]), 64'd0);
      end

      // T5: held strobe gives 1,0,1,0,1,0; IN_HI zero-padded
      adr = {22'b0, 8'd65, 2'b00};
      sel = 4'hf; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      for (int i = 0; i < 3; i++) sb_q.push_back(32'h22);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t5_ack", 64'(ack), ((i % 2) == 0) ? 64'd1 : 64'd0);
         if (ack) begin
            if (sb_q.size() > 0) chk("t5_in_hi", 64'(dat_r), 64'(sb_q.pop_front()));
         end else begin
            chk("t5_dat_idle", 64'(dat_r), 64'd0);
         end
      end
      stb = 1'b0; cyc = 1'b0;
      step();

      // Table: output mux and byte-select masking
      for (int v = 0; v < 9; v++) begin
         fn_out = '0;
         fn_oeb = '0;
         fn_out[vecs[v].pad*N_FUNC +: N_FUNC] = vecs[v].fout;
         fn_oeb[vecs[v].pad*N_FUNC +: N_FUNC] = vecs[v].foeb;
         wb_wr(8'(vecs[v].pad), vecs[v].wdat, vecs[v].wsel);
         wb_rd(8'(vecs[v].pad), vecs[v].exp_cfg, "vec_cfg");
         chk("vec_out", 64'(io_out[vecs[v].pad]), 64'(vecs[v].exp_out));
         chk("vec_oeb", 64'(io_oeb[vecs[v].pad]), 64'(vecs[v].exp_oeb));
      end

      // T6: async reset during an ack cycle and mid filter count
      io_in[10] = 1'b1;
      for (int i = 0; i < 8; i++) step();
      adr = {22'b0, 8'd5, 2'b00}; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      step();
      chk("t6_ack_before", 64'(ack), 64'd1);
      rst = 1'b1;
      #1;
      chk("t6_ack_async", 64'(ack), 64'd0);
      chk("t6_dat_async", 64'(dat_r), 64'd0);
      chk("t6_oeb5", 64'(io_oeb[5]), 64'd1);
      chk("t6_fn_in", 64'(fn_in), 64'd0);
      stb = 1'b0; cyc = 1'b0;
      io_in[10] = 1'b0;
      step();
      rst = 1'b0;
      step();
      wb_rd(8'd5, 32'h200, "t6_cfg5");
      wb_rd(8'd10, 32'h200, "t6_cfg10");
      wb_wr(8'd10, 32'h100, 4'b0010);
      io_in[10] = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         if (i == 16) chk("t6_rise_e16", 64'(fn_in[10]), 64'd0);
         if (i == 17) chk("t6_rise_e17", 64'(fn_in[10]), 64'd1);
      end

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
